// File: rtl/g_nandn_flt_pkg.sv
// g_macro_pkg: shared definitions for the schematic-macro replacement blocks.
//
// Contents:
//    clog2        - ceiling log2 for sizing counters from parameters
//    flt_state_e  - filter state encoding (MATCH = 0, PEND = 1)
//    MAX_LATENCY  - deepest register pipeline a macro may request
//    MAX_FILTER   - largest persistence count a filter may request
package g_macro_pkg;

   localparam int MAX_LATENCY = 8;
   localparam int MAX_FILTER  = 255;

   typedef enum logic {
      MATCH = 1'b0,
      PEND  = 1'b1
   } flt_state_e;

   // Ceiling log2; returns 0 for values of 0 or 1, so callers that need a
   // usable vector width must clamp the result to at least 1 themselves.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result++;
         remain = remain >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/g_nandn_flt_if.sv
// g_nandn_flt_if: signal bundle between a g_nandn_flt and whatever drives it.
//
// Signals:
//    CE   - clock enable from the driver
//    A    - WIDTH gate inputs from the driver
//    YN   - registered, optionally filtered NAND result
//    CHG  - one-cycle strobe on the cycle YN takes a new value
//    CNT  - filter persistence count (debug visibility only)
//
// Modports:
//    master - the side that drives CE/A and observes the results
//    slave  - the g_nandn_flt itself
interface g_nandn_flt_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 1
);

   logic             CE;
   logic [WIDTH-1:0] A;
   logic             YN;
   logic             CHG;
   logic [CNT_W-1:0] CNT;

   modport master (
      output CE, A,
      input  YN, CHG, CNT
   );

   modport slave (
      input  CE, A,
      output YN, CHG, CNT
   );

endinterface

// File: rtl/g_nandn_flt_dly_line.sv
// g_dly_line: parametrised 1-bit delay line with clock enable, synchronous
// clear and a configurable clear/init value.
//
// Ports:
//    clk_i  - clock, stages advance on the rising edge
//    clr_i  - synchronous active-high clear, loads INIT into every stage
//    ce_i   - clock enable; stages hold when low
//    d_i    - serial input
//    q_o    - output of the last stage (DEPTH enabled edges after d_i)
module g_dly_line
   import g_macro_pkg::*;
#(
   parameter int   DEPTH = 1,
   parameter logic INIT  = 1'b1
) (
   input  logic clk_i,
   input  logic clr_i,
   input  logic ce_i,
   input  logic d_i,
   output logic q_o
);

   if (DEPTH < 1 || DEPTH > MAX_LATENCY) begin : gBadDepth
      $error("g_dly_line: DEPTH must be 1..%0d", MAX_LATENCY);
   end

   logic [DEPTH-1:0] stage_q;
   logic [DEPTH-1:0] stage_d;

   // A single-stage line cannot take the shift slice below, so it simply
   // reloads from the input.
   if (DEPTH == 1) begin : gSingle
      assign stage_d = d_i;
   end else begin : gMulti
      assign stage_d = {stage_q[DEPTH-2:0], d_i};
   end

   // Clear wins over enable; with enable low every stage holds.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         stage_q <= {DEPTH{INIT}};
      end else if (ce_i) begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/g_nandn_flt.sv
// g_nandn_flt: N-input NAND with per-input polarity, register pipeline,
// optional persistence (glitch) filter and a registered change strobe.
//
// Ports:
//    CK   - clock, all state updates on the rising edge
//    CD   - synchronous active-high reset, overrides CE
//    bus  - g_nandn_flt_if slave: CE, A in; YN, CHG, CNT out
//
// Parameters: WIDTH (2..16), INV_MASK (bit i inverts A[i]), LATENCY (1..8),
// FILTER (0..255, 0 = unfiltered), INIT (reset value of pipeline and YN).
module g_nandn_flt
   import g_macro_pkg::*;
#(
   parameter int          WIDTH    = 4,
   parameter logic [15:0] INV_MASK = 16'h0003,
   parameter int          LATENCY  = 1,
   parameter int          FILTER   = 0,
   parameter logic        INIT     = 1'b1
) (
   input  logic           CK,
   input  logic           CD,
   g_nandn_flt_if.slave   bus
);

   if (WIDTH < 2 || WIDTH > 16) begin : gBadWidth
      $error("g_nandn_flt: WIDTH must be 2..16");
   end
   if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : gBadLatency
      $error("g_nandn_flt: LATENCY must be 1..%0d", MAX_LATENCY);
   end
   if (FILTER < 0 || FILTER > MAX_FILTER) begin : gBadFilter
      $error("g_nandn_flt: FILTER must be 0..%0d", MAX_FILTER);
   end

   localparam int CNT_RAW = clog2(FILTER + 1);
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
   localparam logic [WIDTH-1:0] MASK = INV_MASK[WIDTH-1:0];

   // Without a filter the YN register itself is the last pipeline stage, so
   // the delay line is one shorter; with a filter the whole pipeline sits in
   // front of the filter and YN is an extra decision register.
   localparam int PIPE_DEPTH = (FILTER == 0) ? LATENCY - 1 : LATENCY;

   logic             raw;
   logic             pipe_out;
   logic             yn_q;
   logic             yn_d;
   logic             chg_q;
   logic             chg_d;
   logic [CNT_W-1:0] cnt;

   assign raw = ~&(bus.A ^ MASK);

   if (PIPE_DEPTH == 0) begin : gNoPipe
      assign pipe_out = raw;
   end else begin : gPipe
      g_dly_line #(
         .DEPTH (PIPE_DEPTH),
         .INIT  (INIT)
      ) u_dly (
         .clk_i (CK),
         .clr_i (CD),
         .ce_i  (bus.CE),
         .d_i   (raw),
         .q_o   (pipe_out)
      );
   end

   if (FILTER == 0) begin : gNoFilter
      // Unfiltered: YN simply takes the next pipeline value on enabled edges.
      always_comb begin
         yn_d = yn_q;
         if (bus.CE) begin
            yn_d = pipe_out;
         end
      end

      assign cnt = '0;
   end else begin : gFilter
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

      flt_state_e       state_q;
      flt_state_e       state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Filter state and persistence count; reset discards any pending run.
      always_ff @(posedge CK) begin
         if (CD) begin
            state_q <= MATCH;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // YN only follows the pipeline once a differing value has been seen
      // on FILTER consecutive enabled edges; any return to agreement before
      // that restarts the count. A FILTER of 1 flips on the first mismatch
      // and never needs the PEND state. cnt tops out at FILTER-1 because
      // that is exactly where the flip happens.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         yn_d    = yn_q;
         if (bus.CE) begin
            case (state_q)
               MATCH: begin
                  if (pipe_out != yn_q) begin
                     if (FILTER == 1) begin
                        yn_d = pipe_out;
                     end else begin
                        state_d = PEND;
                        cnt_d   = CNT_W'(1);
                     end
                  end
               end
               PEND: begin
                  if (pipe_out == yn_q) begin
                     state_d = MATCH;
                     cnt_d   = '0;
                  end else if (cnt_q == CNT_LAST) begin
                     yn_d    = pipe_out;
                     state_d = MATCH;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
               default: begin
                  state_d = MATCH;
                  cnt_d   = '0;
               end
            endcase
         end
      end

      assign cnt = cnt_q;
   end

   // CHG marks the cycle in which YN shows its new value; a disabled cycle
   // can never change YN, so it also forces CHG low.
   assign chg_d = bus.CE & (yn_d != yn_q);

   // Result and strobe registers; reset produces no strobe.
   always_ff @(posedge CK) begin
      if (CD) begin
         yn_q  <= INIT;
         chg_q <= 1'b0;
      end else begin
         yn_q  <= yn_d;
         chg_q <= chg_d;
      end
   end

   assign bus.YN  = yn_q;
   assign bus.CHG = chg_q;
   assign bus.CNT = cnt;

endmodule

// File: tb/tb_g_nandn_flt.sv
// tb_g_nandn_flt: directed and random checks of g_nandn_flt in five
// parameter sets sharing one clock, each with its own reset.
//    u0: defaults (WIDTH 4, INV_MASK 0011, LATENCY 1, FILTER 0)
//    u1: LATENCY 3, FILTER 2, INV_MASK 0
//    u2: LATENCY 1, FILTER 4, INV_MASK 0 (glitch rejection, reset mid-PEND)
//    u3: LATENCY 1, FILTER 3, INV_MASK 0 (clock-enable gating)
//    u4: WIDTH 16, INV_MASK A5A5, LATENCY 2, FILTER 0 (polarity, random)
module tb_g_nandn_flt;

   logic ck;
   logic cd0, cd1, cd2, cd3, cd4;
   int   total;
   int   bad;

   g_nandn_flt_if #(.WIDTH(4),  .CNT_W(1)) if0 ();
   g_nandn_flt_if #(.WIDTH(4),  .CNT_W(2)) if1 ();
   g_nandn_flt_if #(.WIDTH(4),  .CNT_W(3)) if2 ();
   g_nandn_flt_if #(.WIDTH(4),  .CNT_W(2)) if3 ();
   g_nandn_flt_if #(.WIDTH(16), .CNT_W(1)) if4 ();

   g_nandn_flt u0 (.CK(ck), .CD(cd0), .bus(if0.slave));

   g_nandn_flt #(.WIDTH(4), .INV_MASK(16'h0000), .LATENCY(3), .FILTER(2), .INIT(1'b1))
      u1 (.CK(ck), .CD(cd1), .bus(if1.slave));

   g_nandn_flt #(.WIDTH(4), .INV_MASK(16'h0000), .LATENCY(1), .FILTER(4), .INIT(1'b1))
      u2 (.CK(ck), .CD(cd2), .bus(if2.slave));

   g_nandn_flt #(.WIDTH(4), .INV_MASK(16'h0000), .LATENCY(1), .FILTER(3), .INIT(1'b1))
      u3 (.CK(ck), .CD(cd3), .bus(if3.slave));

   g_nandn_flt #(.WIDTH(16), .INV_MASK(16'hA5A5), .LATENCY(2), .FILTER(0), .INIT(1'b1))
      u4 (.CK(ck), .CD(cd4), .bus(if4.slave));

   // 10-unit clock period.
   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   // Advance the given number of rising edges with the inputs currently set,
   // then settle 1 unit past the last edge so outputs can be sampled.
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge ck);
      end
      #1;
   endtask

   // One comparison: counted, and reported with tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   // Directed sequence, one step after another, then the random sweep on u4.
   initial begin
      int   expCnt2[5];
      int   stepCe3[7];
      int   stepA3[7];
      int   expCnt3[7];
      int   expYn3[7];
      int   expChg3[7];
      logic [15:0] aRnd;
      logic        ceRnd;
      logic        mP0;
      logic        mYn;
      logic        expChg;

      total = 0;
      bad   = 0;
      cd0 = 1'b1; cd1 = 1'b1; cd2 = 1'b1; cd3 = 1'b1; cd4 = 1'b1;
      if0.CE = 1'b1; if1.CE = 1'b1; if2.CE = 1'b1; if3.CE = 1'b1; if4.CE = 1'b1;
      if0.A = 4'h0; if1.A = 4'h0; if2.A = 4'h0; if3.A = 4'h0; if4.A = 16'h0000;
      applyStimulus(2);

      // ---- reset values ----
      checkOutput("rst_u0_yn",  if0.YN,  1);
      checkOutput("rst_u0_chg", if0.CHG, 0);
      checkOutput("rst_u0_cnt", 32'(if0.CNT), 0);
      checkOutput("rst_u1_yn",  if1.YN,  1);
      checkOutput("rst_u1_cnt", 32'(if1.CNT), 0);
      checkOutput("rst_u2_cnt", 32'(if2.CNT), 0);
      checkOutput("rst_u4_yn",  if4.YN,  1);

      // ---- u0: defaults, 1100 decodes low, 1101 high, one-edge latency ----
      cd0 = 1'b0;
      if0.A = 4'b1100;
      applyStimulus(1);
      checkOutput("u0_yn_fall",  if0.YN,  0);
      checkOutput("u0_chg_fall", if0.CHG, 1);
      applyStimulus(1);
      checkOutput("u0_yn_hold",  if0.YN,  0);
      checkOutput("u0_chg_once", if0.CHG, 0);
      if0.A = 4'b1101;
      applyStimulus(1);
      checkOutput("u0_yn_rise",  if0.YN,  1);
      checkOutput("u0_chg_rise", if0.CHG, 1);
      applyStimulus(1);
      checkOutput("u0_chg_end",  if0.CHG, 0);

      // ---- u1: LATENCY 3 + FILTER 2, YN falls on the 5th edge ----
      cd1 = 1'b0;
      if1.A = 4'hF;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("u1_yn_e%0d", k),  if1.YN,  (k < 5) ? 1 : 0);
         checkOutput($sformatf("u1_cnt_e%0d", k), 32'(if1.CNT), (k == 4) ? 1 : 0);
         checkOutput($sformatf("u1_chg_e%0d", k), if1.CHG, (k == 5) ? 1 : 0);
      end

      // ---- u2: 3-cycle glitch at p_last with FILTER 4 is rejected ----
      expCnt2 = '{0, 1, 2, 3, 0};
      cd2 = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if2.A = (k < 3) ? 4'hF : 4'h0;
         applyStimulus(1);
         checkOutput($sformatf("u2_glitch_cnt%0d", k), 32'(if2.CNT), expCnt2[k]);
         checkOutput($sformatf("u2_glitch_yn%0d", k),  if2.YN,  1);
         checkOutput($sformatf("u2_glitch_chg%0d", k), if2.CHG, 0);
      end

      // ---- u2: reset while pending with CNT = 2 ----
      if2.A = 4'hF;
      applyStimulus(3);
      checkOutput("u2_pend_cnt", 32'(if2.CNT), 2);
      cd2 = 1'b1;
      applyStimulus(1);
      checkOutput("u2_rst_yn",  if2.YN,  1);
      checkOutput("u2_rst_cnt", 32'(if2.CNT), 0);
      checkOutput("u2_rst_chg", if2.CHG, 0);
      cd2 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(1);
         checkOutput($sformatf("u2_post_yn%0d", k),  if2.YN,  (k < 5) ? 1 : 0);
         checkOutput($sformatf("u2_post_cnt%0d", k), 32'(if2.CNT), expCnt2[k-1]);
         checkOutput($sformatf("u2_post_chg%0d", k), if2.CHG, (k == 5) ? 1 : 0);
      end

      // ---- u3: CE toggling during a FILTER 3 change ----
      // A is pulled back to 0 on disabled cycles; a frozen pipeline ignores it.
      cd3 = 1'b0;
      if3.A = 4'hF;
      applyStimulus(1);
      checkOutput("u3_load_cnt", 32'(if3.CNT), 0);
      checkOutput("u3_load_yn",  if3.YN,  1);
      stepCe3 = '{0, 1, 0, 1, 0, 1, 0};
      stepA3  = '{0, 15, 0, 15, 0, 15, 15};
      expCnt3 = '{0, 1, 1, 2, 2, 0, 0};
      expYn3  = '{1, 1, 1, 1, 1, 0, 0};
      expChg3 = '{0, 0, 0, 0, 0, 1, 0};
      for (int k = 0; k < 7; k++) begin
         if3.CE = stepCe3[k][0];
         if3.A  = stepA3[k][3:0];
         applyStimulus(1);
         checkOutput($sformatf("u3_cnt%0d", k), 32'(if3.CNT), expCnt3[k]);
         checkOutput($sformatf("u3_yn%0d", k),  if3.YN,  expYn3[k]);
         checkOutput($sformatf("u3_chg%0d", k), if3.CHG, expChg3[k]);
      end

      // ---- u4: WIDTH 16, mask A5A5, LATENCY 2 ----
      cd4 = 1'b0;
      if4.A = 16'h5A5A;
      applyStimulus(1);
      checkOutput("u4_yn_lat1", if4.YN, 1);
      applyStimulus(1);
      checkOutput("u4_yn_5a5a",  if4.YN,  0);
      checkOutput("u4_chg_5a5a", if4.CHG, 1);
      if4.A = 16'h5A5B;
      applyStimulus(2);
      checkOutput("u4_yn_5a5b", if4.YN, 1);
      for (int i = 0; i < 16; i++) begin
         if4.A = 16'h5A5A ^ (16'h0001 << i);
         applyStimulus(2);
         checkOutput($sformatf("u4_bit%0d_hi", i), if4.YN, 1);
         if4.A = 16'h5A5A;
         applyStimulus(2);
         checkOutput($sformatf("u4_bit%0d_lo", i), if4.YN, 0);
      end

      // ---- u4: random vectors with random CE against a pipeline model ----
      mP0 = 1'b0;
      mYn = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         case ($urandom_range(0, 3))
            0:       aRnd = 16'h5A5A;
            1:       aRnd = 16'h5A5A ^ (16'h0001 << $urandom_range(0, 15));
            default: aRnd = 16'($urandom);
         endcase
         ceRnd = 1'($urandom_range(0, 1));
         if4.A  = aRnd;
         if4.CE = ceRnd;
         applyStimulus(1);
         if (ceRnd) begin
            expChg = (mP0 != mYn);
            mYn    = mP0;
            mP0    = (aRnd == 16'h5A5A) ? 1'b0 : 1'b1;
         end else begin
            expChg = 1'b0;
         end
         checkOutput("u4_rnd_yn",  if4.YN,  mYn);
         checkOutput("u4_rnd_chg", if4.CHG, expChg);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/g_nandn_flt.md
Name: g_nandn_flt

Overview:
- Parametrised successor to the fixed 4-input mixed-polarity NAND macro used by schematic capture.
- N-input NAND with a per-input polarity mask and a configurable register pipeline.
- Optional glitch/debounce filter on the result and a registered change-strobe.
- Used where schematic NAND decodes feed control logic and need registered, noise-qualified outputs instead of raw gate outputs.

Parameters:
- WIDTH, 4, number of NAND inputs (2..16).
- INV_MASK, 4'b0011, bit i = 1 inverts input A[i] before the NAND (default reproduces the ~AN, ~BN, C, D decode).
- LATENCY, 1, register stages on the raw NAND result (1..8).
- FILTER, 0, consecutive enabled cycles a new value must persist before YN follows (0 = no filter, max 255).
- INIT, 1'b1, reset value of every pipeline stage and of YN.

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- CD  input  1  synchronous active-high reset.
- CE  input  1  clock enable; when low, all state holds.
- A  input  WIDTH  gate inputs; bit i polarity set by INV_MASK[i].
- YN  output  1  registered, optionally filtered NAND result.
- CHG  output  1  one-cycle pulse on the cycle YN takes a new value.
- CNT  output  $clog2(FILTER+1) (min 1)  current filter persistence count; visibility/debug only.

Behaviour:
- Raw result: raw = ~&(A ^ INV_MASK). Purely combinational and not an output.
- Pipeline: LATENCY registers p[0..LATENCY-1]; p[0] <= raw and p[k] <= p[k-1], updated only when CE = 1.
- FILTER = 0: YN <= p[LATENCY-1] when CE = 1. Input-to-YN latency is LATENCY enabled edges.
- FILTER > 0 (filter state machine, states MATCH and PEND):
  - MATCH: p_last == YN, cnt = 0. A mismatch moves to PEND with cnt = 1; if FILTER = 1, YN flips on the same edge and the block stays in MATCH with cnt = 0.
  - PEND: a mismatch with cnt < FILTER-1 increments cnt. A mismatch with cnt == FILTER-1 flips YN, clears cnt and returns to MATCH.
  - PEND: a match (glitch ended) clears cnt and returns to MATCH; YN is unchanged.
  - Input-to-YN latency for a stable change is LATENCY+FILTER enabled edges. Pulses shorter than FILTER cycles at p_last never reach YN.
- CHG: registered; CHG <= (YN_next != YN) & CE, so it is high for exactly the one cycle after YN changes. Reset value 0.
- CE = 0: pipeline, cnt, state and YN all hold; CHG <= 0. Filter persistence counts enabled cycles only.
- CD = 1: overrides CE. Next edge sets all p[k] = INIT, YN = INIT, cnt = 0, state = MATCH, CHG = 0. Reset mid-PEND discards the pending count; no CHG is generated by reset.
- Reset values: YN = INIT, CHG = 0, CNT = 0.
- Width rules:
  - cnt saturates by construction and never exceeds FILTER-1.
  - INV_MASK is truncated or zero-extended to WIDTH.
  - Elaboration error if LATENCY is outside 1..8, FILTER > 255, or WIDTH < 2.

Decomposition:
- Shared package g_macro_pkg:
  - clog2 helper function.
  - Filter state encoding (MATCH = 1'b0, PEND = 1'b1).
  - Parameter-range limits (MAX_LATENCY = 8, MAX_FILTER = 255).
- One sub-module, g_dly_line: a parametrised 1-bit delay line with CE, synchronous clear and init value, implementing the p[] pipeline.
- The NAND, filter and CHG logic stay in g_nandn_flt.

Test Plan:
- Defaults (WIDTH = 4, INV_MASK = 0011, LATENCY = 1, FILTER = 0), CD pulse then A = 4'b1100 -> YN = 0 one edge later with CHG = 1 for one cycle; A = 4'b1101 -> YN = 1 next edge, CHG pulse.
- LATENCY = 3, FILTER = 2, INV_MASK = 0: A = 4'hF held -> YN falls exactly 5 enabled edges after application; CNT observed 1 then 0.
- FILTER = 4: make p_last differ from YN for 3 cycles then return -> YN unchanged, CHG never asserted, CNT goes 1, 2, 3, 0.
- CE toggled 1/0/1/0 during a FILTER = 3 change -> YN flips only after 3 enabled edges; all state frozen on CE = 0 cycles; CHG = 0 while CE = 0.
- Assert CD while in PEND with CNT = 2 (FILTER = 4), A held at mismatch -> next edge YN = INIT, CNT = 0, CHG = 0; the full LATENCY+FILTER delay is then required before YN changes.
- WIDTH = 16, INV_MASK = 16'hA5A5: sweep A = 16'h5A5A (YN -> 0) and 16'h5A5B (YN -> 1) -> correct polarity handling on every bit; compare against a reference model over 10k random vectors with random CE.
